// File: rtl/vx_tl_pkg.sv
// TileLink-UL constants and helpers shared by the core-to-TL memory bridge.
package vx_tl_pkg;

  localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET         = 3'd4;
  localparam logic [2:0] TL_D_ACK         = 3'd0;
  localparam logic [2:0] TL_D_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic [2:0] opcode;
    logic       denied;
    logic       corrupt;
  } tl_d_hdr_t;

  // log2 of the beat size in bytes, as carried in the TL size field
  function automatic logic [3:0] tl_size(input int data_w);
    return 4'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/vx_tl_mem_bridge_if.sv
// Core memory port plus TileLink-UL A/D channels; master is the bridge side.
interface vx_tl_mem_bridge_if #(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 128,
  parameter int TAG_WIDTH    = 15,
  parameter int TL_SRC_WIDTH = 15
);
  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [DATA_WIDTH/8-1:0] mem_req_byteen;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;

  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  logic                    mem_a_valid;
  logic                    mem_a_ready;
  logic [2:0]              mem_a_bits_opcode;
  logic [2:0]              mem_a_bits_param;
  logic [3:0]              mem_a_bits_size;
  logic [TL_SRC_WIDTH-1:0] mem_a_bits_source;
  logic [31:0]             mem_a_bits_address;
  logic [DATA_WIDTH/8-1:0] mem_a_bits_mask;
  logic [DATA_WIDTH-1:0]   mem_a_bits_data;
  logic                    mem_a_bits_corrupt;

  logic                    mem_d_valid;
  logic                    mem_d_ready;
  logic [2:0]              mem_d_bits_opcode;
  logic [TL_SRC_WIDTH-1:0] mem_d_bits_source;
  logic [DATA_WIDTH-1:0]   mem_d_bits_data;
  logic                    mem_d_bits_denied;
  logic                    mem_d_bits_corrupt;

  modport master (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready,
    output mem_a_valid, mem_a_bits_opcode, mem_a_bits_param, mem_a_bits_size, mem_a_bits_source,
           mem_a_bits_address, mem_a_bits_mask, mem_a_bits_data, mem_a_bits_corrupt,
    input  mem_a_ready,
    input  mem_d_valid, mem_d_bits_opcode, mem_d_bits_source, mem_d_bits_data,
           mem_d_bits_denied, mem_d_bits_corrupt,
    output mem_d_ready
  );

  modport slave (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready,
    input  mem_a_valid, mem_a_bits_opcode, mem_a_bits_param, mem_a_bits_size, mem_a_bits_source,
           mem_a_bits_address, mem_a_bits_mask, mem_a_bits_data, mem_a_bits_corrupt,
    output mem_a_ready,
    output mem_d_valid, mem_d_bits_opcode, mem_d_bits_source, mem_d_bits_data,
           mem_d_bits_denied, mem_d_bits_corrupt,
    input  mem_d_ready
  );
endinterface

// File: rtl/vx_tl_rsp_fifo.sv
// Two-entry registered FIFO holding read responses on their way to the core.
module vx_tl_rsp_fifo #(
  parameter int W = 143
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  logic         push, pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/vx_tl_mem_bridge.sv
// Core memory port to TileLink-UL bridge: source-ID pool, tag table, read response FIFO.
module vx_tl_mem_bridge
  import vx_tl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 128,
  parameter int TAG_WIDTH    = 15,
  parameter int NUM_SRC      = 8,
  parameter int TL_SRC_WIDTH = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  vx_tl_mem_bridge_if.master         bus,
  output logic [$clog2(NUM_SRC):0]   outstanding,
  output logic                       busy,
  output logic                       err_denied,
  output logic                       err_proto
);
  localparam int         SRC_IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int         CNT_W  = $clog2(NUM_SRC) + 1;
  localparam logic [3:0] SIZE   = tl_size(DATA_WIDTH);

  logic [NUM_SRC-1:0]   free_q, free_d, alloc_oh, rel_oh, wr_tbl;
  logic [TAG_WIDTH-1:0] tag_tbl [NUM_SRC];
  logic [SRC_IW-1:0]    alloc_idx, src_idx;
  logic [CNT_W-1:0]     cnt_q;
  logic                 free_avail, a_fire, d_fire, release_src, push_req, fifo_in_ready;
  logic                 src_ok, is_ack, is_data, proto_bad;
  tl_d_hdr_t            d_hdr;

  // Lowest free index from the start-of-cycle map; a slot freed this cycle is not eligible yet.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (free_q[i]) alloc_idx = SRC_IW'(i);
  end

  assign free_avail = (|free_q) & ~reset;
  assign a_fire     = bus.mem_req_valid & bus.mem_a_ready & free_avail;

  assign bus.mem_a_valid        = bus.mem_req_valid & free_avail;
  assign bus.mem_req_ready      = bus.mem_a_ready & free_avail;
  assign bus.mem_a_bits_opcode  = !bus.mem_req_rw ? TL_A_GET :
                                  ((&bus.mem_req_byteen) ? TL_A_PUT_FULL : TL_A_PUT_PARTIAL);
  assign bus.mem_a_bits_param   = 3'd0;
  assign bus.mem_a_bits_size    = SIZE;
  assign bus.mem_a_bits_source  = TL_SRC_WIDTH'(alloc_idx);
  assign bus.mem_a_bits_address = 32'(bus.mem_req_addr) << SIZE;
  assign bus.mem_a_bits_mask    = bus.mem_req_rw ? bus.mem_req_byteen : '1;
  assign bus.mem_a_bits_data    = bus.mem_req_data;
  assign bus.mem_a_bits_corrupt = 1'b0;

  assign d_hdr   = '{opcode: bus.mem_d_bits_opcode, denied: bus.mem_d_bits_denied,
                     corrupt: bus.mem_d_bits_corrupt};
  assign src_idx = bus.mem_d_bits_source[SRC_IW-1:0];
  assign src_ok  = (bus.mem_d_bits_source < TL_SRC_WIDTH'(NUM_SRC)) & ~free_q[src_idx];
  assign is_ack  = (d_hdr.opcode == TL_D_ACK);
  assign is_data = (d_hdr.opcode == TL_D_ACK_DATA);

  // Only data beats for live sources can stall; everything else is swallowed immediately.
  assign push_req        = src_ok & is_data;
  assign bus.mem_d_ready = ~reset & (push_req ? fifo_in_ready : 1'b1);
  assign d_fire          = bus.mem_d_valid & bus.mem_d_ready;
  assign release_src     = d_fire & src_ok & (is_ack | is_data);
  assign proto_bad       = ~src_ok | ~(is_ack | is_data) |
                           (is_ack & ~wr_tbl[src_idx]) | (is_data & wr_tbl[src_idx]);

  assign alloc_oh = a_fire      ? (NUM_SRC'(1) << alloc_idx) : '0;
  assign rel_oh   = release_src ? (NUM_SRC'(1) << src_idx)   : '0;
  assign free_d   = (free_q & ~alloc_oh) | rel_oh;

  always_ff @(posedge clock) begin
    if (reset) begin
      free_q     <= '1;
      cnt_q      <= '0;
      err_denied <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      free_q <= free_d;
      case ({a_fire, release_src})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      err_denied <= err_denied | (d_fire & (d_hdr.denied | d_hdr.corrupt));
      err_proto  <= err_proto  | (d_fire & proto_bad);
    end
  end

  always_ff @(posedge clock) begin
    if (a_fire) begin
      tag_tbl[alloc_idx] <= bus.mem_req_tag;
      wr_tbl[alloc_idx]  <= bus.mem_req_rw;
    end
  end

  vx_tl_rsp_fifo #(.W(DATA_WIDTH + TAG_WIDTH)) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.mem_d_valid & push_req & ~reset),
    .in_ready  (fifo_in_ready),
    .in_data   ({bus.mem_d_bits_data, tag_tbl[src_idx]}),
    .out_valid (bus.mem_rsp_valid),
    .out_ready (bus.mem_rsp_ready),
    .out_data  ({bus.mem_rsp_data, bus.mem_rsp_tag})
  );

  assign outstanding = cnt_q;
  assign busy        = (cnt_q != '0) | bus.mem_rsp_valid;
endmodule
